// File: rtl/line_buffer_ctrl.sv
// Line buffer producer: ping-pongs the input stream into two line SRAMs
// and presents top/mid/bottom rows plus a trailing flush row to the scaler.
module line_buffer_ctrl #(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int PARAM_WIDTH = 11
) (
    input  logic                   I_CLK,
    input  logic                   I_RSTN,
    input  logic                   i_vsync,
    input  logic                   i_hsync,
    input  logic                   i_den,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_sram_en,
    output logic                   o_sram_we0,
    output logic                   o_sram_we1,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    output logic [DATA_WIDTH-1:0]  o_sram_wdata,
    input  logic [DATA_WIDTH-1:0]  i_sram_q0,
    input  logic [DATA_WIDTH-1:0]  i_sram_q1,
    output logic                   o_vsync,
    output logic                   o_hsync,
    output logic                   o_den,
    output logic [PARAM_WIDTH-1:0] o_vact_state,
    output logic [PARAM_WIDTH-1:0] o_hor_cnt,
    output logic [DATA_WIDTH-1:0]  o_sram_rd1,
    output logic [DATA_WIDTH-1:0]  o_sram_rd2,
    output logic [DATA_WIDTH-1:0]  o_sram_rd3
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] H_MAX  = CW'(H_ACT);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
    localparam logic [PARAM_WIDTH-1:0] V_LAST   = PARAM_WIDTH'(V_ACT - 1);
    localparam logic [PARAM_WIDTH-1:0] L_ONE    = PARAM_WIDTH'(1);
    localparam logic [PARAM_WIDTH-1:0] VS_FIRST = PARAM_WIDTH'(3);
    localparam logic [PARAM_WIDTH-1:0] VS_MID   = PARAM_WIDTH'(5);
    localparam logic [PARAM_WIDTH-1:0] VS_LAST  = PARAM_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_FLUSH_WAIT,
        S_FLUSH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_vsync_d;
    logic                   r_hsync_d;
    logic                   r_den_d;
    logic                   r_skip;
    logic [CW-1:0]          r_pix_cnt;
    logic [CW-1:0]          w_pix_cnt_nxt;
    logic [CW-1:0]          w_pix_inc;
    logic [PARAM_WIDTH-1:0] r_line_cnt;
    logic [PARAM_WIDTH-1:0] w_line_cnt_nxt;
    logic                   r_wr_bank;
    logic                   w_wr_bank_nxt;
    logic                   r_rd_bank;
    logic                   r_den;
    logic [PARAM_WIDTH-1:0] r_hor_cnt;
    logic [PARAM_WIDTH-1:0] r_vact;
    logic [DATA_WIDTH-1:0]  r_rd3;

    logic w_vs_rise;
    logic w_hs_rise;
    logic w_den;
    logic w_den_fall;
    logic w_active;
    logic w_in_range;
    logic w_wr;
    logic w_flush;
    logic w_rd;

    // A frame abort in mid-line discards the rest of that den burst.
    assign w_den      = i_den & ~r_skip;
    assign w_vs_rise  = i_vsync & ~r_vsync_d;
    assign w_hs_rise  = i_hsync & ~r_hsync_d;
    assign w_den_fall = ~w_den & r_den_d;
    assign w_pix_inc  = r_pix_cnt + 1'b1;
    assign w_in_range = r_pix_cnt < H_MAX;

    assign w_active = ((r_state == S_FILL) || (r_state == S_STREAM)) && !w_vs_rise;
    assign w_flush  = (r_state == S_FLUSH) && !w_vs_rise;
    assign w_wr     = w_active && w_den && w_in_range;
    assign w_rd     = (w_wr && (r_state == S_STREAM)) || w_flush;

    assign o_sram_en    = w_wr || w_flush;
    assign o_sram_we0   = w_wr && !r_wr_bank;
    assign o_sram_we1   = w_wr && r_wr_bank;
    assign o_sram_addr  = r_pix_cnt[ADDR_WIDTH-1:0];
    assign o_sram_wdata = i_data;

    always_comb begin
        w_state_nxt    = r_state;
        w_pix_cnt_nxt  = r_pix_cnt;
        w_line_cnt_nxt = r_line_cnt;
        w_wr_bank_nxt  = r_wr_bank;
        if (w_vs_rise) begin
            w_state_nxt    = S_FILL;
            w_pix_cnt_nxt  = '0;
            w_line_cnt_nxt = '0;
            w_wr_bank_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_pix_cnt_nxt = '0;
                end
                S_FILL, S_STREAM: begin
                    if (w_den_fall) begin
                        w_pix_cnt_nxt  = '0;
                        w_line_cnt_nxt = r_line_cnt + L_ONE;
                        w_wr_bank_nxt  = ~r_wr_bank;
                        if (r_state == S_FILL) begin
                            w_state_nxt = S_STREAM;
                        end else if (r_line_cnt == V_LAST) begin
                            w_state_nxt = S_FLUSH_WAIT;
                        end
                    end else if (w_den && w_in_range) begin
                        w_pix_cnt_nxt = w_pix_inc;
                    end
                end
                S_FLUSH_WAIT: begin
                    if (w_hs_rise) begin
                        w_state_nxt   = S_FLUSH;
                        w_pix_cnt_nxt = '0;
                    end
                end
                S_FLUSH: begin
                    if (r_pix_cnt == H_LAST) begin
                        w_state_nxt    = S_IDLE;
                        w_pix_cnt_nxt  = '0;
                        w_line_cnt_nxt = '0;
                    end else begin
                        w_pix_cnt_nxt = w_pix_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            r_state    <= S_IDLE;
            r_vsync_d  <= 1'b0;
            r_hsync_d  <= 1'b0;
            r_den_d    <= 1'b0;
            r_skip     <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vsync_d  <= i_vsync;
            r_hsync_d  <= i_hsync;
            r_den_d    <= w_den & ~w_vs_rise;
            r_skip     <= w_vs_rise ? i_den : (r_skip & i_den);
            r_pix_cnt  <= w_pix_cnt_nxt;
            r_line_cnt <= w_line_cnt_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= r_wr_bank;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            r_den     <= 1'b0;
            r_hor_cnt <= '0;
            r_vact    <= '0;
            r_rd3     <= '0;
        end else begin
            r_den     <= w_rd;
            r_hor_cnt <= w_rd ? PARAM_WIDTH'(w_pix_inc) : '0;
            if (w_flush) begin
                r_vact <= VS_LAST;
            end else if (w_rd) begin
                r_vact <= (r_line_cnt == L_ONE) ? VS_FIRST : VS_MID;
            end else begin
                r_vact <= '0;
            end
            r_rd3 <= w_flush ? '0 : i_data;
        end
    end

    // The bank being written returns its previous line (read-first).
    assign o_sram_rd1 = !r_den ? '0 : (r_rd_bank ? i_sram_q1 : i_sram_q0);
    assign o_sram_rd2 = !r_den ? '0 : (r_rd_bank ? i_sram_q0 : i_sram_q1);
    assign o_sram_rd3 = r_rd3;

    assign o_vsync      = r_vsync_d;
    assign o_hsync      = r_hsync_d;
    assign o_den        = r_den;
    assign o_vact_state = r_vact;
    assign o_hor_cnt    = r_hor_cnt;

endmodule
